// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    D_ACC  = 2'd2
  } state_t;

  // Requester identifiers recorded at grant time
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Default bus widths
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch (IF) and load/store (D) requesters.
// D wins by default; after STARVE_MAX consecutive D grants while IF is
// waiting, IF is forced to win the next grant.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_en,
  output logic gnt_if,
  output logic gnt_d
);

  localparam int SW = $clog2(STARVE_MAX + 2);

  logic [SW-1:0] starve_cnt;
  logic          d_win;

  // Grant decision: D wins unless IF is waiting and has been starved long enough
  always_comb begin
    d_win  = d_req && (!if_req || (starve_cnt < SW'(STARVE_MAX)));
    gnt_d  = grant_en && d_win;
    gnt_if = grant_en && !d_win && if_req;
  end

  // Starvation counter: only evaluated while the arbiter is able to grant
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (gnt_if || !if_req) begin
        starve_cnt <= '0;
      end else if (gnt_d && (starve_cnt < SW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported instruction/data memory between the fetch stage
// (IF) and the load/store stage (D). Each access holds the memory lines for
// MEM_LAT cycles and finishes with a one-cycle ack pulse to the requester.
// Optional build macro MEM_ARB_PERF_EN adds per-requester stall counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       d_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             acc_we;
  logic             owner;
  logic             gnt_if, gnt_d;
  logic             idle;

  assign idle = (state == IDLE);

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .d_req   (d_req),
    .grant_en(idle),
    .gnt_if  (gnt_if),
    .gnt_d   (gnt_d)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: grant from IDLE, return to IDLE when the latency count expires
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_d) begin
          state_nxt = D_ACC;
        end else if (gnt_if) begin
          state_nxt = IF_ACC;
        end
      end
      IF_ACC, D_ACC: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Access registers: latch the winner, count latency, capture read data and ack
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      acc_we    <= 1'b0;
      owner     <= REQ_IF;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (idle) begin
        if (gnt_d) begin
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          acc_we    <= d_we;
          owner     <= REQ_D;
          cnt       <= CNT_W'(MEM_LAT - 1);
        end else if (gnt_if) begin
          mem_addr  <= if_addr;
          acc_we    <= 1'b0;
          owner     <= REQ_IF;
          cnt       <= CNT_W'(MEM_LAT - 1);
        end
      end else if (cnt == '0) begin
        if (owner == REQ_IF) begin
          if_rdata <= mem_rdata;
          if_ack   <= 1'b1;
        end else begin
          if (!acc_we) begin
            d_rdata <= mem_rdata;
          end
          d_ack <= 1'b1;
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Memory strobes are only active while an access is in flight
  assign mem_read  = !idle && !acc_we;
  assign mem_write = !idle && acc_we;
  assign busy      = !idle;

`ifdef MEM_ARB_PERF_EN
  // Stall counters: cycles with a request pending and no ack, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      if_stall_cnt <= '0;
      d_stall_cnt  <= '0;
    end else begin
      if (if_req && !if_ack && (if_stall_cnt != '1)) begin
        if_stall_cnt <= if_stall_cnt + 32'd1;
      end
      if (d_req && !d_ack && (d_stall_cnt != '1)) begin
        d_stall_cnt <= d_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported instruction/data Memory between two requesters: the CPU fetch stage (IF) and the load/store stage (D).
- Serialises requests and drives the memory address, data, read-enable and write-enable lines for a fixed access latency.
- Returns read data with a one-cycle ack pulse.
- Sits between the CPU pipeline and the Memory model; the pipeline stalls on pending requests.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles memory lines are held per access (>=1)
- STARVE_MAX, 4, consecutive D grants with IF waiting before IF is forced to win

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid when if_ack
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_ack
- d_ack  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, latency counter 0, starvation counter 0.
- States: IDLE, IF_ACC, D_ACC.
- IDLE grant rule, evaluated at each edge:
  - If d_req is high and (if_req is low or starve_cnt < STARVE_MAX): go to D_ACC.
  - Otherwise, if if_req is high: go to IF_ACC.
  - Otherwise, stay in IDLE.
  - D has priority by default because it belongs to the older instruction.
- On grant, register the winner's address, wdata and we, and load cnt = MEM_LAT-1.
- In an ACC state:
  - mem_addr shows the latched address.
  - mem_read = !we, mem_write = we (always we = 0 for IF).
  - All of these are held constant for exactly MEM_LAT cycles.
- Completion: at the edge where cnt == 0:
  - Capture mem_rdata into the requester's rdata register (stores leave d_rdata unchanged).
  - Assert that requester's ack for the following cycle.
  - Return to IDLE.
- Latency: req sampled in IDLE -> ack high MEM_LAT+1 cycles later. With MEM_LAT = 2 that is a 3-cycle access.
- Outside ACC: mem_read = mem_write = 0; mem_addr and mem_wdata hold their last values.
- The ack cycle is IDLE, so a new grant may occur at the ack edge (back-to-back throughput: one access per MEM_LAT+1 cycles).
- A requester keeping req high during its ack cycle is treated as issuing a new request.
- A req withdrawn before grant is dropped. A req dropped after grant is ignored; the access completes and ack still pulses.
- Starvation counter:
  - Increments on each D grant while if_req is high.
  - Clears on each IF grant, and on any IDLE cycle with if_req low.
  - Saturates at STARVE_MAX.
- Reset mid-access aborts the access: no ack, and mem_read/mem_write are 0 from the next cycle.
- if_ack and d_ack are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds outputs if_stall_cnt and d_stall_cnt (32 bits each).
  - Each counts cycles in which its req is high and its ack is low.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, IF_ACC, D_ACC)
  - requester ID constants (REQ_IF, REQ_D)
  - ADDR_W and DATA_W defaults
- Sub-module mem_arb_prio: holds the starvation counter and the grant decision (inputs if_req, d_req, grant_en; outputs gnt_if, gnt_d).
- Top-level block: FSM, latency counter, output registers.

Test Plan:
- Reset held 3 cycles with random requests -> all outputs 0, busy 0, no acks.
- IF only, if_addr = 0x40, mem_rdata = 0x8C0A0004, MEM_LAT = 2 -> mem_read = 1 and mem_addr = 0x40 for 2 cycles; if_ack pulses in cycle 3 with if_rdata = 0x8C0A0004; mem_write stays 0 throughout.
- Simultaneous requests, store d_addr = 0x100, d_wdata = 0xDEADBEEF, and IF 0x44 -> first mem_write = 1 for 2 cycles at 0x100 with wdata 0xDEADBEEF; d_ack at cycle 3; IF granted at that edge; if_ack at cycle 6.
- Starvation, STARVE_MAX = 4, d_req re-asserted continuously, if_req held -> 4 D accesses, then the 5th grant goes to IF; starve_cnt then returns to 0.
- Reset asserted in the 2nd cycle of a D load -> no d_ack; mem_read = 0 next cycle; state IDLE.
- With MEM_ARB_PERF_EN, the simultaneous-request scenario -> d_stall_cnt = 3, if_stall_cnt = 6 after both acks.
